// File: rtl/bram_arbiter.sv
// Three-port arbiter in front of a single-port-style BRAM with a registered read.
// One access is issued per clock; read data is steered back to its requester one cycle later.
module bram_arbiter #(
    parameter int unsigned PRIO_FIXED = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        req2,
    input  logic        we0,
    input  logic        we1,
    input  logic        we2,
    input  logic [7:0]  addr0,
    input  logic [7:0]  addr1,
    input  logic [7:0]  addr2,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    input  logic [15:0] wdata2,
    output logic        gnt0,
    output logic        gnt1,
    output logic        gnt2,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic        rvalid2,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic [15:0] rdata2,
    output logic [7:0]  ram_addr,
    output logic        ram_we,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata
);

    function automatic logic [1:0] inc3(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            2'd2:    nxt = 2'd0;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    // First requester found walking three slots upward (with wrap) from start.
    function automatic logic [2:0] pick(input logic [2:0] req, input logic [1:0] start);
        logic [2:0] g;
        logic [1:0] c;
        g = 3'b000;
        c = start;
        for (int k = 0; k < 3; k++) begin
            if ((g == 3'b000) && req[c]) begin
                g[c] = 1'b1;
            end else begin
                g = g;
            end
            c = inc3(c);
        end
        return g;
    endfunction

    logic [1:0]  last_q, last_d;
    logic [7:0]  addr_hold_q, addr_hold_d;
    logic        rd_valid_q, rd_valid_d;
    logic [1:0]  rd_port_q, rd_port_d;

    logic [2:0]  req_s;
    logic [1:0]  start_s;
    logic [2:0]  gnt_s;
    logic        gnt_any_s;
    logic [1:0]  gnt_idx_s;
    logic        sel_we_s;
    logic [7:0]  sel_addr_s;
    logic [15:0] sel_wdata_s;
    logic [7:0]  ram_addr_s;

    // Grant selection; requests are masked while reset is asserted.
    always_comb begin
        req_s   = rst_n ? {req2, req1, req0} : 3'b000;
        start_s = (PRIO_FIXED != 0) ? 2'd0 : inc3(last_q);
        gnt_s   = pick(req_s, start_s);
        gnt_any_s = |gnt_s;
        case (gnt_s)
            3'b001:  gnt_idx_s = 2'd0;
            3'b010:  gnt_idx_s = 2'd1;
            3'b100:  gnt_idx_s = 2'd2;
            default: gnt_idx_s = 2'd0;
        endcase
    end

    // Access mux for the granted port.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = 8'h00;
        sel_wdata_s = 16'h0000;
        case (gnt_idx_s)
            2'd0: begin
                sel_we_s    = we0;
                sel_addr_s  = addr0;
                sel_wdata_s = wdata0;
            end
            2'd1: begin
                sel_we_s    = we1;
                sel_addr_s  = addr1;
                sel_wdata_s = wdata1;
            end
            2'd2: begin
                sel_we_s    = we2;
                sel_addr_s  = addr2;
                sel_wdata_s = wdata2;
            end
            default: begin
                sel_we_s    = 1'b0;
                sel_addr_s  = 8'h00;
                sel_wdata_s = 16'h0000;
            end
        endcase
    end

    // RAM-side drive and next-state for pointer, address hold and read pipeline.
    always_comb begin
        ram_addr_s  = gnt_any_s ? sel_addr_s : addr_hold_q;
        addr_hold_d = ram_addr_s;
        last_d      = gnt_any_s ? gnt_idx_s : last_q;
        rd_valid_d  = gnt_any_s & ~sel_we_s;
        rd_port_d   = gnt_any_s ? gnt_idx_s : rd_port_q;
    end

    // State registers; last resets to 2 so port 0 leads the first search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= 2'd2;
            addr_hold_q <= 8'h00;
            rd_valid_q  <= 1'b0;
            rd_port_q   <= 2'd0;
        end else begin
            last_q      <= last_d;
            addr_hold_q <= addr_hold_d;
            rd_valid_q  <= rd_valid_d;
            rd_port_q   <= rd_port_d;
        end
    end

    // Output drive; read data is zeroed on ports without a valid pulse.
    always_comb begin
        gnt0      = gnt_s[0];
        gnt1      = gnt_s[1];
        gnt2      = gnt_s[2];
        ram_addr  = ram_addr_s;
        ram_we    = gnt_any_s & sel_we_s;
        ram_wdata = gnt_any_s ? sel_wdata_s : 16'h0000;
        rvalid0   = rd_valid_q && (rd_port_q == 2'd0);
        rvalid1   = rd_valid_q && (rd_port_q == 2'd1);
        rvalid2   = rd_valid_q && (rd_port_q == 2'd2);
        rdata0    = rvalid0 ? ram_rdata : 16'h0000;
        rdata1    = rvalid1 ? ram_rdata : 16'h0000;
        rdata2    = rvalid2 ? ram_rdata : 16'h0000;
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: a round-robin and a fixed-priority instance share
// stimulus, each with its own registered-read RAM model.
module tb_bram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, req2 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0, we2 = 1'b0;
    logic [7:0]  addr0 = 8'h00, addr1 = 8'h00, addr2 = 8'h00;
    logic [15:0] wdata0 = 16'h0000, wdata1 = 16'h0000, wdata2 = 16'h0000;

    logic        rr_gnt0, rr_gnt1, rr_gnt2, rr_rv0, rr_rv1, rr_rv2, rr_we;
    logic [15:0] rr_rd0, rr_rd1, rr_rd2, rr_wdata, rr_ram_rdata;
    logic [7:0]  rr_addr;
    logic        fx_gnt0, fx_gnt1, fx_gnt2, fx_rv0, fx_rv1, fx_rv2, fx_we;
    logic [15:0] fx_rd0, fx_rd1, fx_rd2, fx_wdata, fx_ram_rdata;
    logic [7:0]  fx_addr;

    logic [15:0] mem_rr [0:255];
    logic [15:0] mem_fx [0:255];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bram_arbiter #(.PRIO_FIXED(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .req2(req2),
        .we0(we0), .we1(we1), .we2(we2),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .gnt0(rr_gnt0), .gnt1(rr_gnt1), .gnt2(rr_gnt2),
        .rvalid0(rr_rv0), .rvalid1(rr_rv1), .rvalid2(rr_rv2),
        .rdata0(rr_rd0), .rdata1(rr_rd1), .rdata2(rr_rd2),
        .ram_addr(rr_addr), .ram_we(rr_we), .ram_wdata(rr_wdata),
        .ram_rdata(rr_ram_rdata)
    );

    bram_arbiter #(.PRIO_FIXED(1)) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .req2(req2),
        .we0(we0), .we1(we1), .we2(we2),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .gnt0(fx_gnt0), .gnt1(fx_gnt1), .gnt2(fx_gnt2),
        .rvalid0(fx_rv0), .rvalid1(fx_rv1), .rvalid2(fx_rv2),
        .rdata0(fx_rd0), .rdata1(fx_rd1), .rdata2(fx_rd2),
        .ram_addr(fx_addr), .ram_we(fx_we), .ram_wdata(fx_wdata),
        .ram_rdata(fx_ram_rdata)
    );

    wire [2:0] rr_gnt = {rr_gnt2, rr_gnt1, rr_gnt0};
    wire [2:0] rr_rv  = {rr_rv2, rr_rv1, rr_rv0};
    wire [2:0] fx_gnt = {fx_gnt2, fx_gnt1, fx_gnt0};

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return {8'hA5, a};
    endfunction

    function automatic logic [15:0] pat(input logic [7:0] a);
        return {a ^ 8'h3C, a};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_rr[i] = init_val(8'(i));
            mem_fx[i] = init_val(8'(i));
        end
    end

    // RAM models: write and registered read on the same edge.
    always @(posedge clk) begin
        if (rr_we) mem_rr[rr_addr] <= rr_wdata;
        rr_ram_rdata <= mem_rr[rr_addr];
        if (fx_we) mem_fx[fx_addr] <= fx_wdata;
        fx_ram_rdata <= mem_fx[fx_addr];
    end

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
        we0 = 1'b0; we1 = 1'b0; we2 = 1'b0;
    endtask

    // Leaves rst_n low; the caller releases it together with its first stimulus.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
        we0 = 1'b1; addr0 = 8'h33; wdata0 = 16'h7777;
        #1;
        checks++; if (rr_gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b want 000", rr_gnt); end
        checks++; if (rr_rv !== 3'b000) begin errors++; $display("FAIL reset_rvalid got %b want 000", rr_rv); end
        checks++; if (rr_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b want 0", rr_we); end
        checks++; if (rr_addr !== 8'h00) begin errors++; $display("FAIL reset_ram_addr got %h want 00", rr_addr); end
        checks++; if (rr_wdata !== 16'h0000) begin errors++; $display("FAIL reset_ram_wdata got %h want 0000", rr_wdata); end
        checks++; if ({rr_rd0, rr_rd1, rr_rd2} !== 48'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", {rr_rd0, rr_rd1, rr_rd2}); end
        checks++; if (fx_gnt !== 3'b000) begin errors++; $display("FAIL reset_fx_gnt got %b want 000", fx_gnt); end
        idle_inputs();
    endtask

    task automatic test_write_read();
        do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 16'hBEEF;
        #1;
        checks++; if (rr_gnt !== 3'b001) begin errors++; $display("FAIL wr_gnt got %b want 001", rr_gnt); end
        checks++; if (rr_we !== 1'b1) begin errors++; $display("FAIL wr_ram_we got %b want 1", rr_we); end
        checks++; if (rr_addr !== 8'h10) begin errors++; $display("FAIL wr_ram_addr got %h want 10", rr_addr); end
        checks++; if (rr_wdata !== 16'hBEEF) begin errors++; $display("FAIL wr_ram_wdata got %h want beef", rr_wdata); end
        @(negedge clk);
        we0 = 1'b0; wdata0 = 16'h0000;
        #1;
        checks++; if (rr_gnt !== 3'b001) begin errors++; $display("FAIL rd_gnt got %b want 001", rr_gnt); end
        checks++; if (rr_we !== 1'b0) begin errors++; $display("FAIL rd_ram_we got %b want 0", rr_we); end
        checks++; if (rr_rv !== 3'b000) begin errors++; $display("FAIL wr_no_rvalid got %b want 000", rr_rv); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (rr_gnt !== 3'b000) begin errors++; $display("FAIL idle_gnt got %b want 000", rr_gnt); end
        checks++; if (rr_rv !== 3'b001) begin errors++; $display("FAIL rd_rvalid got %b want 001", rr_rv); end
        checks++; if (rr_rd0 !== 16'hBEEF) begin errors++; $display("FAIL rd_rdata0 got %h want beef", rr_rd0); end
        checks++; if (rr_rd1 !== 16'h0000) begin errors++; $display("FAIL rd_rdata1 got %h want 0000", rr_rd1); end
        checks++; if (rr_addr !== 8'h10) begin errors++; $display("FAIL idle_addr_hold got %h want 10", rr_addr); end
        checks++; if (rr_wdata !== 16'h0000) begin errors++; $display("FAIL idle_wdata got %h want 0000", rr_wdata); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g;
        logic [2:0] prev_g;
        logic [1:0] prev_i;
        do_reset();
        prev_g = 3'b000;
        prev_i = 2'd0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rst_n = 1'b1;
            req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
            we0 = 1'b0; we1 = 1'b0; we2 = 1'b0;
            addr0 = 8'h20; addr1 = 8'h21; addr2 = 8'h22;
            #1;
            exp_g = 3'b001 << (c % 3);
            checks++; if (rr_gnt !== exp_g) begin errors++; $display("FAIL rr_gnt cycle %0d got %b want %b", c, rr_gnt, exp_g); end
            checks++; if (rr_rv !== prev_g) begin errors++; $display("FAIL rr_rvalid cycle %0d got %b want %b", c, rr_rv, prev_g); end
            if (c > 0) begin
                checks++;
                if (rr_ram_rdata !== init_val(8'h20 + 8'(prev_i)) ||
                    (prev_i == 2'd0 && rr_rd0 !== init_val(8'h20)) ||
                    (prev_i == 2'd1 && rr_rd1 !== init_val(8'h21)) ||
                    (prev_i == 2'd2 && rr_rd2 !== init_val(8'h22))) begin
                    errors++;
                    $display("FAIL rr_rdata cycle %0d got %h/%h/%h want %h on port %0d", c, rr_rd0, rr_rd1, rr_rd2, init_val(8'h20 + 8'(prev_i)), prev_i);
                end
            end
            prev_g = exp_g;
            prev_i = 2'(c % 3);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rst_n = 1'b1;
            req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
            #1;
            checks++; if (fx_gnt !== 3'b001) begin errors++; $display("FAIL fx_gnt_all cycle %0d got %b want 001", c, fx_gnt); end
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            req0 = 1'b0;
            #1;
            checks++; if (fx_gnt !== 3'b010) begin errors++; $display("FAIL fx_gnt_12 cycle %0d got %b want 010", c, fx_gnt); end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_same_addr();
        do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00;
        #1;
        checks++; if (rr_gnt !== 3'b001) begin errors++; $display("FAIL sa_setup_gnt got %b want 001", rr_gnt); end
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h05;
        req2 = 1'b1; we2 = 1'b1; addr2 = 8'h05; wdata2 = 16'h1234;
        #1;
        checks++; if (rr_gnt !== 3'b010) begin errors++; $display("FAIL sa_gnt1 got %b want 010", rr_gnt); end
        @(negedge clk);
        req1 = 1'b0;
        #1;
        checks++; if (rr_gnt !== 3'b100) begin errors++; $display("FAIL sa_gnt2 got %b want 100", rr_gnt); end
        checks++; if (rr_rv1 !== 1'b1 || rr_rd1 !== init_val(8'h05)) begin errors++; $display("FAIL sa_old_data rvalid1=%b rdata1=%h want 1/%h", rr_rv1, rr_rd1, init_val(8'h05)); end
        @(negedge clk);
        req2 = 1'b0; we2 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
        #1;
        checks++; if (rr_gnt !== 3'b001) begin errors++; $display("FAIL sa_gnt0 got %b want 001", rr_gnt); end
        checks++; if (rr_rv !== 3'b000) begin errors++; $display("FAIL sa_write_rvalid got %b want 000", rr_rv); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (rr_rv0 !== 1'b1 || rr_rd0 !== 16'h1234) begin errors++; $display("FAIL sa_new_data rvalid0=%b rdata0=%h want 1/1234", rr_rv0, rr_rd0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        #1;
        checks++; if (rr_gnt !== 3'b001) begin errors++; $display("FAIL rm_gnt got %b want 001", rr_gnt); end
        @(negedge clk);
        rst_n = 1'b0;
        req1 = 1'b1; req2 = 1'b1;
        #1;
        checks++; if (rr_rv !== 3'b000) begin errors++; $display("FAIL rm_rvalid got %b want 000", rr_rv); end
        checks++; if (rr_gnt !== 3'b000) begin errors++; $display("FAIL rm_gnt_in_reset got %b want 000", rr_gnt); end
        checks++; if (rr_addr !== 8'h00 || rr_we !== 1'b0 || rr_wdata !== 16'h0000) begin errors++; $display("FAIL rm_ram_outs got %h/%b/%h want 00/0/0000", rr_addr, rr_we, rr_wdata); end
        checks++; if (rr_rd0 !== 16'h0000) begin errors++; $display("FAIL rm_rdata0 got %h want 0000", rr_rd0); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (rr_gnt !== 3'b001) begin errors++; $display("FAIL rm_first_gnt got %b want 001", rr_gnt); end
        checks++; if (rr_rv !== 3'b000) begin errors++; $display("FAIL rm_rvalid_after got %b want 000", rr_rv); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            req2 = 1'b1; we2 = 1'b1; addr2 = 8'(i); wdata2 = pat(8'(i));
            #1;
            checks++; if (rr_gnt !== 3'b100 || rr_addr !== 8'(i)) begin errors++; $display("FAIL b2b_wr_gnt i=%0d got %b/%h want 100/%h", i, rr_gnt, rr_addr, 8'(i)); end
        end
        for (int j = 0; j < 256; j++) begin
            @(negedge clk);
            req2 = 1'b1; we2 = 1'b0; addr2 = 8'(j);
            #1;
            checks++; if (rr_gnt !== 3'b100) begin errors++; $display("FAIL b2b_rd_gnt j=%0d got %b want 100", j, rr_gnt); end
            if (j == 0) begin
                checks++; if (rr_rv !== 3'b000) begin errors++; $display("FAIL b2b_first_rvalid got %b want 000", rr_rv); end
            end else begin
                checks++;
                if (rr_rv !== 3'b100 || rr_rd2 !== pat(8'(j - 1))) begin
                    errors++;
                    $display("FAIL b2b_rdata j=%0d got %b/%h want 100/%h", j, rr_rv, rr_rd2, pat(8'(j - 1)));
                end
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (rr_rv !== 3'b100 || rr_rd2 !== pat(8'hFF)) begin errors++; $display("FAIL b2b_last got %b/%h want 100/%h", rr_rv, rr_rd2, pat(8'hFF)); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_fixed_priority();
        test_same_addr();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter: PRIO_FIXED, default 0, meaning 0 = round-robin arbitration, 1 = fixed priority with port 0 highest and port 2 lowest.
REQ-002 Port: clk  input  1  single clock for all logic, and the clock driven to the RAM rclk/wclk.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Ports: reqN  input  1  access request, for N=0..2; held high until granted.
REQ-005 Ports: weN  input  1  1 = write, 0 = read; valid while reqN is high.
REQ-006 Ports: addrN  input  8  word address, valid while reqN is high.
REQ-007 Ports: wdataN  input  16  write data, valid while reqN and weN are high.
REQ-008 Ports: gntN  output  1  one-cycle grant pulse; the access is issued to the RAM in this cycle.
REQ-009 Ports: rvalidN  output  1  one-cycle pulse; read data for port N is on rdataN.
REQ-010 Ports: rdataN  output  16  read data; meaningful only while rvalidN is high.
REQ-011 Port: ram_addr  output  8  address to the RAM; drives both raddr and waddr.
REQ-012 Port: ram_we  output  1  RAM write enable.
REQ-013 Port: ram_wdata  output  16  RAM write data.
REQ-014 Port: ram_rdata  input  16  RAM read data, registered inside the RAM, one clk after the address.

Function
REQ-015 At most one gntN SHALL be high per cycle; gntN is combinational from the req inputs and the priority pointer.
REQ-016 PRIO_FIXED=0: the search order SHALL start at (last+1) mod 3, where last is the index of the most recent grant.
REQ-017 PRIO_FIXED=1: the search order SHALL be 0,1,2 every cycle, and last SHALL be ignored.
REQ-018 last SHALL update on the clk edge ending a cycle with a grant, and SHALL hold when no request is pending.
REQ-019 In a cycle with gntN high, ram_addr=addrN, ram_we=weN and ram_wdata=wdataN SHALL hold.
REQ-020 With no grant: ram_we=0, ram_addr holds its previous value (registered mux-select hold), and ram_wdata=0.
REQ-021 A granted read SHALL drive rvalidN high exactly one cycle after gntN, with rdataN=ram_rdata in that cycle.
REQ-022 A granted write SHALL never produce rvalidN.
REQ-023 A read pipeline register SHALL hold the port index and a valid bit; back-to-back grants SHALL be accepted every cycle (throughput 1 access per clk).
REQ-024 Requester rule: after seeing gntN, the requester SHALL drop reqN or present a new access in the next cycle; the arbiter treats a still-high reqN as a new request.
REQ-025 rdataN for ports without rvalidN SHALL be 0.
REQ-026 Simultaneous requests on all three ports under round-robin SHALL produce the grant sequence last+1, last+2, last+3, with each port starving at most 2 cycles.
REQ-027 A read and a write to the same address SHALL never be issued in the same cycle (guaranteed by the single grant).
REQ-028 A write to address A followed by a read of A in the next cycle SHALL return the new data.

Reset
REQ-029 While rst_n=0: all gntN=0, rvalidN=0, rdataN=0, ram_we=0, ram_addr=0, ram_wdata=0, last=2 (so port 0 wins first), and the read pipeline valid bit is cleared.
REQ-030 Reset asserted in the cycle after a read grant SHALL suppress the pending rvalid; no rvalid SHALL appear after reset is released.
REQ-031 The first grant SHALL be possible in the first clk edge after rst_n rises.

Verification
REQ-032 req0 write addr 0x10 data 0xBEEF, then req0 read 0x10 -> gnt0 on both; rvalid0 one cycle after the read gnt with rdata0=0xBEEF.
REQ-033 All reqs held high as reads, PRIO_FIXED=0, after reset -> grants 0,1,2,0,1,2; each rvalidN lags its gntN by 1.
REQ-034 Same stimulus, PRIO_FIXED=1 -> gnt0 every cycle, and gnt1/gnt2 never while req0 is high.
REQ-035 req1 read 0x05 and req2 write 0x05=0x1234 in the same cycle, last=0 -> gnt1 first with the old data, gnt2 next cycle; a subsequent read returns 0x1234.
REQ-036 rst_n pulled low in the cycle after a read gnt -> no rvalid; all outputs 0; port 0 is granted first after release.
REQ-037 Single port, 256 consecutive writes then 256 reads, one per cycle -> 512 consecutive grants with no bubbles, and every read returns its written data.
